// File: rtl/crypt_sequencer.sv
// Accepts GO/USB-trigger requests, latches plaintext/key, waits a programmable delay, starts the AES core.
// Drives the capture trigger for the whole encryption; the watchdog aborts a stuck core; requests made while busy are counted and dropped.
module crypt_sequencer #(
    parameter int pPT_WIDTH    = 128,
    parameter int pKEY_WIDTH   = 128,
    parameter int pDELAY_WIDTH = 16,
    parameter int pTIMEOUT     = 4096
) (
    input  logic                    crypto_clk,
    input  logic                    reset_i,
    input  logic                    I_go,
    input  logic                    I_usb_trigger,
    input  logic [pPT_WIDTH-1:0]    I_textin,
    input  logic [pKEY_WIDTH-1:0]   I_key,
    input  logic [pDELAY_WIDTH-1:0] I_delay,
    input  logic                    I_clear_error,
    output logic [pPT_WIDTH-1:0]    O_core_pt,
    output logic [pKEY_WIDTH-1:0]   O_core_key,
    output logic                    O_core_start,
    input  logic                    I_core_ready,
    input  logic                    I_core_done,
    input  logic [pPT_WIDTH-1:0]    I_core_ct,
    output logic [pPT_WIDTH-1:0]    O_cipherout,
    output logic                    O_busy,
    output logic                    O_done,
    output logic                    O_trigger,
    output logic                    O_error,
    output logic [7:0]              O_missed
);

    localparam int WD_W = $clog2(pTIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(pTIMEOUT - 1);
    localparam logic [pDELAY_WIDTH-1:0] DELAY_ONE = pDELAY_WIDTH'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_START = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    logic [1:0]              state;
    logic [2:0]              trig_sync;
    logic [pDELAY_WIDTH-1:0] delay_cnt;
    logic [WD_W-1:0]         wd_cnt;
    logic                    trig_req;
    logic                    request;

    // Bits [1:0] are the synchronizer; bit 2 only remembers the previous level for edge detection.
    assign trig_req     = trig_sync[1] & ~trig_sync[2];
    assign request      = I_go | trig_req;
    assign O_core_start = (state == ST_START) & I_core_ready;
    assign O_trigger    = (state == ST_RUN);
    assign O_busy       = (state != ST_IDLE);

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            state       <= ST_IDLE;
            trig_sync   <= '0;
            delay_cnt   <= '0;
            wd_cnt      <= '0;
            O_core_pt   <= '0;
            O_core_key  <= '0;
            O_cipherout <= '0;
            O_done      <= 1'b0;
            O_error     <= 1'b0;
            O_missed    <= '0;
        end else begin
            trig_sync <= {trig_sync[1:0], I_usb_trigger};
            O_done    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (request) begin
                        O_core_pt  <= I_textin;
                        O_core_key <= I_key;
                        delay_cnt  <= I_delay;
                        state      <= (I_delay != '0) ? ST_DELAY : ST_START;
                    end
                end
                ST_DELAY: begin
                    delay_cnt <= delay_cnt - DELAY_ONE;
                    if (delay_cnt == DELAY_ONE) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (I_core_ready) begin
                        wd_cnt <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A done landing on the final watchdog cycle still counts as success.
                    if (I_core_done) begin
                        O_cipherout <= I_core_ct;
                        O_done      <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (wd_cnt == WD_LAST) begin
                        O_error <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Clear is last so it overrides both a drop and a same-cycle abort.
            if (I_clear_error) begin
                O_error  <= 1'b0;
                O_missed <= '0;
            end else if (request && (state != ST_IDLE) && (O_missed != 8'hff)) begin
                O_missed <= O_missed + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_crypt_sequencer.sv
// Bench for crypt_sequencer: timestamp-based reference model plus a stub AES core with programmable latency.
module tb_crypt_sequencer;

    localparam int TMO = 16;

    logic         crypto_clk = 1'b0;
    logic         reset_i, I_go, I_usb_trigger, I_clear_error;
    logic [127:0] I_textin, I_key, I_core_ct;
    logic [15:0]  I_delay;
    logic [127:0] O_core_pt, O_core_key, O_cipherout;
    logic         O_core_start, I_core_ready, I_core_done;
    logic         O_busy, O_done, O_trigger, O_error;
    logic [7:0]   O_missed;

    always #5 crypto_clk = ~crypto_clk;

    crypt_sequencer #(
        .pPT_WIDTH(128), .pKEY_WIDTH(128), .pDELAY_WIDTH(16), .pTIMEOUT(TMO)
    ) dut (
        .crypto_clk(crypto_clk), .reset_i(reset_i), .I_go(I_go),
        .I_usb_trigger(I_usb_trigger), .I_textin(I_textin), .I_key(I_key),
        .I_delay(I_delay), .I_clear_error(I_clear_error),
        .O_core_pt(O_core_pt), .O_core_key(O_core_key), .O_core_start(O_core_start),
        .I_core_ready(I_core_ready), .I_core_done(I_core_done), .I_core_ct(I_core_ct),
        .O_cipherout(O_cipherout), .O_busy(O_busy), .O_done(O_done),
        .O_trigger(O_trigger), .O_error(O_error), .O_missed(O_missed)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Stub core
    int           stub_cnt = 0;
    int           stub_lat = 1;
    bit           stub_hang = 0;
    logic [127:0] stub_pt, stub_key;

    // Reference model: one transaction described by its accept/start/done cycles
    int           m_acc, m_start, m_end, m_missed, m_nacc, n_start;
    logic [127:0] m_ct, m_ct_next, m_pt, m_key;
    bit           lvl_h1, lvl_h2, lvl_h3;

    function automatic logic [127:0] ct_fn(input logic [127:0] pt, input logic [127:0] key);
        return {pt[0], pt[127:1]} ^ key ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one cycle; the stub samples the start strobe mid-cycle and answers after the edge.
    task automatic tick();
        @(negedge crypto_clk);
        if (O_core_start === 1'b1) begin
            stub_cnt = stub_lat;
            stub_pt  = O_core_pt;
            stub_key = O_core_key;
        end
        @(posedge crypto_clk);
        #1;
        cyc++;
        I_core_done = 1'b0;
        I_core_ct   = rnd128();
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0 && !stub_hang) begin
                I_core_done = 1'b1;
                I_core_ct   = ct_fn(stub_pt, stub_key);
            end
        end
    endtask

    task automatic model_reset(input logic [127:0] ct, input int missed);
        m_acc = -100; m_start = -100; m_end = -100;
        m_ct = ct; m_ct_next = ct; m_missed = missed;
        lvl_h1 = 0; lvl_h2 = 0; lvl_h3 = 0;
    endtask

    task automatic mcheck();
        bit e_busy, e_start, e_trig, e_done;
        e_busy  = (cyc > m_acc) && (cyc <= m_end);
        e_start = (cyc == m_start);
        e_trig  = (cyc > m_start) && (cyc <= m_end);
        e_done  = (cyc == m_end + 1);
        if (e_done) m_ct = m_ct_next;
        if (O_core_start === 1'b1) n_start++;
        chk("busy", 128'(O_busy), 128'(e_busy));
        chk("core_start", 128'(O_core_start), 128'(e_start));
        chk("trigger", 128'(O_trigger), 128'(e_trig));
        chk("done", 128'(O_done), 128'(e_done));
        chk("cipherout", O_cipherout, m_ct);
        chk("missed", 128'(O_missed), 128'(m_missed));
        chk("error", 128'(O_error), 128'(0));
        if (e_busy) begin
            chk("core_pt", O_core_pt, m_pt);
            chk("core_key", O_core_key, m_key);
        end
    endtask

    // One model-checked cycle: check outputs, then drive this cycle's inputs and update the model.
    task automatic mcyc(input bit go, input bit lvl, input logic [15:0] d, input int lat,
                        input logic [127:0] pt, input logic [127:0] key);
        bit req;
        tick();
        mcheck();
        I_go = go; I_usb_trigger = lvl; I_delay = d; I_textin = pt; I_key = key;
        req = go | (lvl_h2 & ~lvl_h3);
        if (req) begin
            if (cyc > m_end) begin
                m_acc = cyc; m_start = cyc + 1 + int'(d); m_end = m_start + lat;
                m_pt = pt; m_key = key; m_ct_next = ct_fn(pt, key);
                stub_lat = lat; m_nacc++;
            end else if (m_missed < 255) begin
                m_missed++;
            end
        end
        lvl_h3 = lvl_h2; lvl_h2 = lvl_h1; lvl_h1 = lvl;
    endtask

    task automatic midle(input int n);
        for (int i = 0; i < n; i++) mcyc(0, 0, 16'd0, 1, rnd128(), rnd128());
    endtask

    initial begin
        logic [127:0] pt1, key1, pt2, ct_keep, pt_s, key_s;
        bit rl;
        pt1  = 128'h12345678abcdef0187654321deadbeef;
        key1 = 128'habcdef0112345678deadbeef87654321;
        pt2  = 128'h12345678abcdef0187654321deadbe01;
        reset_i = 1; I_go = 0; I_usb_trigger = 0; I_clear_error = 0; I_delay = '0;
        I_textin = '0; I_key = '0; I_core_ready = 1; I_core_done = 0; I_core_ct = '0;
        m_nacc = 0; n_start = 0;
        model_reset('0, 0);

        repeat (3) tick();
        chk("rst_busy", 128'(O_busy), 128'(0));
        chk("rst_trigger", 128'(O_trigger), 128'(0));
        chk("rst_cipherout", O_cipherout, 128'(0));
        chk("rst_core_pt", O_core_pt, 128'(0));
        chk("rst_missed_error", 128'({O_missed, O_error, O_done, O_core_start}), 128'(0));
        reset_i = 0;

        // Spec vector with D=0, then a held USB trigger, then a 5-cycle delay
        mcyc(1, 0, 16'd0, 3, pt1, key1);
        midle(8);
        chk("vec1_ct", O_cipherout, ct_fn(pt1, key1));
        for (int i = 0; i < 10; i++) mcyc(0, 1, 16'd0, 4, pt2, key1);
        midle(10);
        chk("usb_ct", O_cipherout, ct_fn(pt2, key1));
        chk("usb_missed", 128'(O_missed), 128'(0));
        mcyc(1, 0, 16'd5, 4, rnd128(), rnd128());
        midle(15);

        // GO coinciding with a USB edge request is a single start
        mcyc(0, 1, 16'd0, 2, rnd128(), rnd128());
        mcyc(0, 1, 16'd0, 2, rnd128(), rnd128());
        mcyc(1, 1, 16'd0, 2, rnd128(), rnd128());
        midle(10);
        chk("coincide_missed", 128'(O_missed), 128'(0));

        rl = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) rl = ~rl;
            mcyc($urandom_range(5) == 0, rl, 16'($urandom_range(4)), 1 + $urandom_range(5),
                 rnd128(), rnd128());
        end
        midle(20);
        chk("start_count", 128'(n_start), 128'(m_nacc));

        // Core not ready: flood with GO pulses, saturate the drop counter, then release
        I_clear_error = 1; tick(); I_clear_error = 0;
        tick();
        chk("clr_missed", 128'(O_missed), 128'(0));
        pt_s = rnd128(); key_s = rnd128();
        I_core_ready = 0; I_go = 1; I_delay = 0; I_textin = pt_s; I_key = key_s;
        for (int i = 0; i < 300; i++) begin
            tick();
            I_textin = rnd128(); I_key = rnd128();
            if (i == 150) chk("stall_start", 128'(O_core_start), 128'(0));
        end
        I_go = 0;
        tick();
        chk("sat_missed", 128'(O_missed), 128'(255));
        chk("stall_busy", 128'(O_busy), 128'(1));
        I_go = 1; I_clear_error = 1;
        tick();
        I_go = 0; I_clear_error = 0;
        chk("clear_wins", 128'(O_missed), 128'(0));
        stub_lat = 2; I_core_ready = 1;
        #1;
        chk("ready_start", 128'(O_core_start), 128'(1));
        tick();
        chk("stall_trig", 128'(O_trigger), 128'(1));
        tick(); tick();
        chk("stall_done", 128'(O_done), 128'(1));
        chk("stall_ct", O_cipherout, ct_fn(pt_s, key_s));
        chk("stall_idle", 128'({O_busy, O_trigger}), 128'(0));
        tick();
        chk("done_width", 128'(O_done), 128'(0));
        ct_keep = ct_fn(pt_s, key_s);

        // Watchdog abort with a core that never finishes
        stub_hang = 1; I_go = 1; I_textin = rnd128();
        tick();
        I_go = 0;
        chk("tmo_start", 128'(O_core_start), 128'(1));
        for (int i = 0; i < TMO; i++) begin
            tick();
            chk("tmo_run", 128'({O_trigger, O_busy, O_error}), 128'(3'b110));
        end
        tick();
        chk("tmo_error", 128'(O_error), 128'(1));
        chk("tmo_idle", 128'({O_busy, O_trigger, O_done}), 128'(0));
        chk("tmo_ct", O_cipherout, ct_keep);
        stub_hang = 0;
        I_core_done = 1;
        tick();
        chk("late_done_ignored", O_cipherout, ct_keep);
        I_clear_error = 1;
        tick();
        I_clear_error = 0;
        chk("err_clear", 128'(O_error), 128'(0));

        // Reset in the middle of RUN
        stub_lat = 6; I_go = 1; I_textin = rnd128();
        tick();
        I_go = 0;
        tick();
        I_go = 1;
        tick();
        I_go = 0;
        chk("pre_rst_missed", 128'(O_missed), 128'(1));
        chk("pre_rst_trig", 128'(O_trigger), 128'(1));
        reset_i = 1;
        tick();
        reset_i = 0;
        chk("mid_rst_ctl", 128'({O_busy, O_trigger, O_done, O_core_start, O_error, O_missed}), 128'(0));
        chk("mid_rst_ct", O_cipherout, 128'(0));
        chk("mid_rst_ptkey", O_core_pt | O_core_key, 128'(0));
        model_reset('0, 0);
        midle(8);
        mcyc(1, 0, 16'd2, 3, pt1, key1);
        midle(10);
        chk("post_rst_ct", O_cipherout, ct_fn(pt1, key1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
